serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around the team's half-adder-based full adder cell `fa_using_ha` (ports a, b, c, sum, carry). It accepts two parallel operands and a carry-in through a valid/ready handshake, then feeds one bit pair per clock, LSB first, into the full adder cell. A carry flip-flop closes the loop, and the sum bits are shifted into a result register. It is the sequencing stage directly upstream of the full adder: it drives the cell's a/b/c inputs and consumes its sum/carry outputs.

## Interface
- WIDTH, 8: operand and result width in bits; legal range ≥ 1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- start_valid  input  1  operands a_in, b_in and cin are valid.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a_in  input  WIDTH  operand A, sampled on acceptance only.
- b_in  input  WIDTH  operand B, sampled on acceptance only.
- cin  input  1  carry-in, sampled on acceptance only.
- sum_out  output  WIDTH  result; valid while done_valid is high.
- cout  output  1  final carry; valid while done_valid is high.
- done_valid  output  1  result is available.
- done_ready  input  1  consumer takes the result.
- busy  output  1  high in SHIFT state.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE
  - start_ready = 1.
  - On start_valid & start_ready: load a_sh ← a_in, b_sh ← b_in, carry_q ← cin, res ← 0, bit count cnt ← 0; go to SHIFT.
- SHIFT
  - The full adder cell gets a = a_sh[0], b = b_sh[0], c = carry_q.
  - Each cycle:
    - a_sh and b_sh shift right by 1, with 0 filled in at the MSB.
    - res shifts right with the cell's sum entering at bit WIDTH-1.
    - carry_q ← cell carry.
    - cnt ← cnt + 1.
  - When cnt == WIDTH-1 at the edge, go to DONE.
- DONE
  - sum_out = res and cout = carry_q, both held stable.
  - done_valid = 1.
  - On done_ready, go to IDLE.
- Arithmetic: {cout, sum_out} = a_in + b_in + cin, computed modulo 2^(WIDTH+1). There is no overflow flag; cout is the overflow.
- cnt is ceil(log2(WIDTH+1)) bits wide and never wraps during a transaction.
- start_valid is ignored in SHIFT and DONE; operand inputs may change freely there.
- Same cycle as DONE→IDLE: start_ready is still 0, so no new transaction is accepted. A new acceptance is possible one cycle later.
- Reset asserted mid-operation, in any state:
  - state goes to IDLE immediately (asynchronously).
  - a_sh, b_sh, res, carry_q and cnt clear to 0.
  - The in-flight transaction is discarded and no result is produced.
- WIDTH = 1: SHIFT lasts exactly one cycle.

## Timing
- Reset values:
  - start_ready = 1, busy = 0, done_valid = 0.
  - sum_out = 0, cout = 0.
- Acceptance edge is E0. SHIFT occupies the cycles after E0 through E_WIDTH.
- done_valid rises after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput: at most one result per WIDTH+2 cycles when done_ready is held high.
- sum_out and cout are registered outputs; there is no combinational path from inputs to outputs.
- start_ready and done_valid are pure decodes of registered state.
- Backpressure: done_valid and the result hold indefinitely while done_ready = 0.

## Test plan
- Reset then idle: rst_n low, then high → start_ready = 1, done_valid = 0, sum_out = 0, cout = 0.
- WIDTH = 8, a = 8'h3C, b = 8'h0F, cin = 0 → after 8 cycles sum_out = 8'h4B, cout = 0, done_valid = 1.
- a = 8'hFF, b = 8'h01, cin = 0 → sum_out = 8'h00, cout = 1. Also a = 8'h5A, b = 8'hA5, cin = 1 → sum_out = 8'h00, cout = 1.
- Backpressure and ignored start:
  - Hold done_ready = 0 for 5 cycles while toggling start_valid with new operands.
  - Required: result stays 8'h4B/0 and start_ready stays 0.
  - Then done_ready = 1 → IDLE, and start_ready = 1 on the next cycle.
- Reset mid-SHIFT: assert rst_n low at cycle 3 of a transaction → immediate IDLE with all outputs at reset values. A following 8'h01 + 8'h01 gives 8'h02, cout = 0.
- Exhaustive at WIDTH = 1: all 8 combinations of a, b, cin match the full adder truth table, e.g. 1+1+1 → sum 1, cout 1, with done_valid one cycle after acceptance.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder.
//
// Operands are accepted in parallel through a start handshake, then fed one
// bit pair per clock, LSB first, into the fa_using_ha full adder cell. A
// carry flop closes the loop and sum bits are shifted into the result
// register from the MSB end. After WIDTH shift cycles the result is
// presented through a done handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  a_in / b_in / cin are valid
//   start_ready  block can accept operands (IDLE only)
//   a_in, b_in   operands, sampled on acceptance only
//   cin          carry-in, sampled on acceptance only
//   sum_out      result, valid while done_valid is high
//   cout         final carry, valid while done_valid is high
//   done_valid   result available
//   done_ready   consumer takes the result
//   busy         high while shifting
//   state_dbg    current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high. start_ready and done_valid are decoded from
// registered state only, so neither depends combinationally on the other side.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module fa_using_ha (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b), .sum(s1),  .carry(c1));
  half_adder u_ha1 (.a(s1), .b(c), .sum(sum), .carry(c2));

  // Both half adders can never carry at once, so OR is enough.
  assign carry = c1 | c2;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             accept;
  logic             last_bit;

  fa_using_ha u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_next = fa_sum;
    end else begin : g_res_multi
      assign res_next = {fa_sum, res[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decodes
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        accept      = start_valid;
        if (start_valid) next_state = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= a_in;
      b_sh    <= b_in;
      res     <= '0;
      carry_q <= cin;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res     <= res_next;
      carry_q <= fa_carry;
      cnt     <= cnt + CW'(1);
    end
  end

  // Result and carry are registers; they are frozen outside SHIFT.
  assign sum_out   = res;
  assign cout      = carry_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH = 8 instance ----------------
  logic       sv8, sr8, cin8, dv8, dr8, busy8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .cin(cin8),
    .sum_out(sum8), .cout(cout8),
    .done_valid(dv8), .done_ready(dr8),
    .busy(busy8), .state_dbg(st8)
  );

  // ---------------- WIDTH = 1 instance ----------------
  logic       sv1, sr1, cin1, dv1, dr1, busy1, cout1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] st1;

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv1), .start_ready(sr1),
    .a_in(a1), .b_in(b1), .cin(cin1),
    .sum_out(sum1), .cout(cout1),
    .done_valid(dv1), .done_ready(dr1),
    .busy(busy1), .state_dbg(st1)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [8:0] exp_q[$];   // {cout, sum} for WIDTH = 8
  logic [1:0] exp1_q[$];  // {cout, sum} for WIDTH = 1

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition, truncated to WIDTH+1 bits.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[8:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Runs one WIDTH=8 transaction to DONE (result left pending) and checks
  // latency plus result against the head of exp_q.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    int lat;
    int guard;
    logic [8:0] exp;
    guard = 0;
    sv8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    while (!sr8 && guard < 20) begin step(); guard++; end
    check({tag, "_ready_timeout"}, 32'(guard < 20), 32'd1);
    step();  // acceptance edge E0
    sv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    lat = 0;
    while (!dv8 && lat < 40) begin step(); lat++; end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    exp = exp_q.pop_front();
    check({tag, "_result"}, 32'({cout8, sum8}), 32'(exp));
  endtask

  task automatic finish8(input string tag);
    dr8 = 1'b1;
    check({tag, "_ready_low_in_done"}, 32'(sr8), 32'd0);
    step();
    dr8 = 1'b0;
    check({tag, "_back_idle"}, 32'({sr8, dv8, busy8}), 32'b100);
  endtask

  task automatic txn1(input logic a, input logic b, input logic c);
    int lat;
    logic [1:0] exp;
    sv1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    check("w1_start_ready", 32'(sr1), 32'd1);
    step();
    sv1 = 1'b0;
    lat = 0;
    while (!dv1 && lat < 10) begin step(); lat++; end
    check("w1_latency", 32'(lat), 32'd1);
    exp = exp1_q.pop_front();
    check("w1_result", 32'({cout1, sum1}), 32'(exp));
    dr1 = 1'b1;
    step();
    dr1 = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] sum;
    logic       co;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    sv8 = 0; a8 = 0; b8 = 0; cin8 = 0; dr8 = 0;
    sv1 = 0; a1 = 0; b1 = 0; cin1 = 0; dr1 = 0;

    // Reset then idle
    step(); step();
    check("rst_outputs8", 32'({sr8, dv8, busy8, cout8, sum8}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    check("rst_state8", 32'(st8), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_outputs8", 32'({sr8, dv8, busy8, cout8, sum8}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    check("idle_outputs1", 32'({sr1, dv1, busy1, cout1, sum1}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

    // Directed table
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({vt[i].co, vt[i].sum});
      start8(vt[i].a, vt[i].b, vt[i].c, $sformatf("vec%0d", i));
      finish8($sformatf("vec%0d", i));
    end

    // Backpressure with ignored start requests
    exp_q.push_back({1'b0, 8'h4B});
    start8(8'h3C, 8'h0F, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      sv8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      step();
      check("bp_hold_result", 32'({cout8, sum8}), 32'({1'b0, 8'h4B}));
      check("bp_hold_flags", 32'({sr8, dv8}), 32'b01);
    end
    sv8 = 1'b1;
    dr8 = 1'b1;
    step();
    dr8 = 1'b0;
    // start_valid was high across DONE->IDLE; it must not have been taken.
    check("bp_release", 32'({sr8, dv8, busy8}), 32'b100);
    sv8 = 1'b0;

    // Reset in the middle of SHIFT
    exp_q.push_back(model8(8'h77, 8'h11, 1'b1));
    sv8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1;
    step();
    sv8 = 1'b0;
    step(); step(); step();
    check("mid_busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", 32'({sr8, dv8, busy8, cout8, sum8}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    void'(exp_q.pop_front());  // discarded transaction
    step();
    rst_n = 1'b1;
    step();
    exp_q.push_back({1'b0, 8'h02});
    start8(8'h01, 8'h01, 1'b0, "post_reset");
    finish8("post_reset");

    // Randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      exp_q.push_back(model8(ra, rb, rc));
      start8(ra, rb, rc, "rand");
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        step();
        check("rand_hold", 32'(dv8), 32'd1);
      end
      finish8("rand");
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    // Exhaustive WIDTH = 1 against the full-adder truth table
    for (int k = 0; k < 8; k++) begin
      logic [2:0] abc;
      int s;
      abc = 3'(k);
      s = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
      exp1_q.push_back(s[1:0]);
      txn1(abc[2], abc[1], abc[0]);
    end

    check("queue_drained", 32'(exp_q.size() + exp1_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "timeout");
  end

endmodule
